keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and decodes each press to a 4-bit key code.
//  Emits exactly one single-cycle strobe per physical press.
//  Sits directly upstream of the BCD digit register, driving its number and cleanSignal inputs.
//  Codes 0-9 are digits; A-F are function keys (A reset-all, C clear) consumed by the control FSM.
// PARAMETERS
//  SCAN_DIV      1000    clock cycles each column is driven before rotating (>=4)
//  DEBOUNCE_CNT  20000   consecutive stable cycles required to accept press or release (>=2)
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-high reset
//  rows         in   4  keypad rows, active-low, external pull-ups, asynchronous to clock
//  cols         out  4  keypad column drive, active-low, exactly one bit low at all times
//  number       out  4  code of last accepted key; held until the next accepted press
//  cleanSignal  out  1  one-cycle strobe, high in the cycle number takes a new code
//  keyHeld      out  1  high while an accepted key remains pressed (HELD state)
// BEHAVIOUR
//  Reset (async, active-high): cols=4'b1110, number=0, cleanSignal=0, keyHeld=0, state=SCAN, all counters and synchroniser flops=0xF/0.
//  rows pass through a 2-flop synchroniser (rows_s); the FSM only sees rows_s.
//  Key map (row r, col c): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D.
//  FSM:
//   SCAN: rotate cols every SCAN_DIV cycles, col0->col1->col2->col3->col0.
//    On the last dwell cycle of a column, if rows_s has exactly one bit low: latch col index and row pattern, stop rotating, go DEBOUNCE.
//    Zero or >=2 rows low -> keep scanning (multi-key ghosting ignored).
//   DEBOUNCE: cols held. Count cycles with rows_s == latched pattern.
//    Any mismatch -> counter=0, back to SCAN (rotation resumes at next column).
//    When count reaches DEBOUNCE_CNT: number<=decoded code, cleanSignal=1 for that one cycle, go HELD.
//   HELD: keyHeld=1, cols held, no auto-repeat. Count consecutive cycles with rows_s==4'b1111.
//    Any low row resets the count. At DEBOUNCE_CNT -> keyHeld=0, go SCAN at next column.
//  cleanSignal is registered; never high two cycles in a row; never asserted outside the DEBOUNCE->HELD transition.
//  Latency: stable press at pins -> strobe = 2 (sync) + DEBOUNCE_CNT + 1 cycles, plus up to 4*SCAN_DIV scan wait.
//  Boundaries:
//   - Counter saturates; no wrap.
//   - Release during DEBOUNCE -> no strobe.
//   - Second key pressed while HELD (same or other column) -> ignored until full release.
//   - Reset mid-DEBOUNCE or mid-HELD -> no strobe; number returns to 0.
//   - Simultaneous keys in different columns: first column reached in scan order wins.
// STRUCTURE
//  Package keypad_pkg: state enum {SCAN, DEBOUNCE, HELD};
//   key code constants KEY_A..KEY_F, KEY_STAR=4'hE, KEY_HASH=4'hF;
//   function decode_key(col_idx, row_idx) -> [3:0].
//  Sub-module stable_counter: counts consecutive cycles a match input is high, clears on low,
//   asserts done at DEBOUNCE_CNT; shared by DEBOUNCE and HELD states.
//  Top holds synchroniser, scan divider/rotator, FSM and output registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8; keypad model drives rows from the current cols)
//  Press key '5' (r1,c1) for 60 cycles -> exactly one strobe with number=4'h5; keyHeld high until 8+2 cycles after release.
//  Press '9' with 3-cycle bounce pulses for first 20 cycles, then stable -> single strobe, number=4'h9; no strobe during bounce.
//  Hold '1', then additionally press '2' while HELD; release both -> one strobe, number=4'h1 only.
//  Press r0 and r1 in col0 together -> no strobe; cols keeps rotating 1110,1101,1011,0111.
//  Assert reset 5 cycles into DEBOUNCE of key 'C' -> cleanSignal stays 0, number=0, cols=1110 immediately (async).
//  Press '*' then '#' separately -> strobes with number=4'hE then 4'hF; number holds 4'hF afterwards.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner:
//   state_t     - scanner FSM states (SCAN, DEBOUNCE, HELD)
//   KEY_*       - codes of the function keys (A..F, '*' and '#')
//   one_low     - true when exactly one active-low row is asserted
//   row_index   - row number of a one-hot-low row pattern
//   decode_key  - (column, row) position to 4-bit key code
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_E    = 4'hE;
    localparam logic [3:0] KEY_F    = 4'hF;
    localparam logic [3:0] KEY_STAR = KEY_E;
    localparam logic [3:0] KEY_HASH = KEY_F;

    function automatic logic one_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Layout:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
    function automatic logic [3:0] decode_key(input logic [1:0] col_idx,
                                              input logic [1:0] row_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_A;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_B;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix pins and the decoded-key outputs.
//   rows        - keypad rows, active-low, asynchronous to the clock
//   cols        - keypad column drive, active-low, one bit low at a time
//   number      - code of the last accepted key
//   cleanSignal - one-cycle strobe when number takes a new code
//   keyHeld     - high while an accepted key is still pressed
// master: the scanner side; slave: the keypad / downstream side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] number;
    logic       cleanSignal;
    logic       keyHeld;

    modport master (
        input  rows,
        output cols,
        output number,
        output cleanSignal,
        output keyHeld
    );

    modport slave (
        output rows,
        input  cols,
        input  number,
        input  cleanSignal,
        input  keyHeld
    );
endinterface

// File: rtl/keypad_scanner_stable_counter.sv
// -----------------------------------------------------------------------------
// stable_counter
// Counts consecutive cycles in which match is high while en is high. Any cycle
// with match low, en low or clr high restarts the count. done is raised in the
// cycle that completes DEBOUNCE_CNT consecutive matches (and stays high while
// matching continues); the count saturates instead of wrapping.
//   clock, reset - clock and asynchronous active-high reset
//   en           - counting enabled (owner FSM is in a timed state)
//   clr          - restart the count at the next edge (state change)
//   match        - input condition being timed this cycle
//   done         - DEBOUNCE_CNT consecutive matches reached
// -----------------------------------------------------------------------------
module stable_counter #(
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic match,
    output logic done
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [CW-1:0] cnt_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= CW'(DEBOUNCE_CNT)) begin
            return CW'(DEBOUNCE_CNT);
        end
        return v + CW'(1);
    endfunction

    // The current matching cycle is the last one needed, so done is
    // combinational and the owner can act on the same edge.
    assign done = en && match && (cnt_q >= CW'(DEBOUNCE_CNT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr || !en || !match) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, synchronises and debounces the rows,
// and emits one cleanSignal strobe per accepted press with the key code on
// number. Function keys A..F pass through as codes for the control FSM.
//   clock - system clock, rising edge
//   reset - asynchronous, active-high
//   kp    - keypad_scanner_if.master (rows in; cols, number, cleanSignal,
//           keyHeld out)
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic             clock,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    rows_p0;
    logic [3:0]    rows_s;
    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] div_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    cols_q;
    logic [3:0]    pat_q;
    logic [3:0]    number_q;
    logic          clean_q;
    logic          held_q;

    logic          last_dwell;
    logic          advance;
    logic          latch;
    logic          strobe;
    logic          cnt_en;
    logic          cnt_clr;
    logic          cnt_match;
    logic          cnt_done;

    assign kp.cols        = cols_q;
    assign kp.number      = number_q;
    assign kp.cleanSignal = clean_q;
    assign kp.keyHeld     = held_q;

    assign last_dwell = (div_q == DW'(SCAN_DIV - 1));
    assign cnt_en     = (state_q != SCAN);
    // DEBOUNCE times the latched press pattern; HELD times the all-released pattern.
    assign cnt_match  = (state_q == HELD) ? (rows_s == 4'hF) : (rows_s == pat_q);

    stable_counter #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_stable (
        .clock(clock),
        .reset(reset),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .match(cnt_match),
        .done (cnt_done)
    );

    // ---- stage p0/s: two-flop row synchroniser ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_p0 <= 4'hF;
            rows_s  <= 4'hF;
        end else begin
            rows_p0 <= kp.rows;
            rows_s  <= rows_p0;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        latch   = 1'b0;
        strobe  = 1'b0;
        case (state_q)
            SCAN: begin
                // rows_s lags the pins by two cycles, so only the last dwell
                // cycle reliably reflects the column currently driven.
                if (last_dwell) begin
                    if (one_low(rows_s)) begin
                        latch   = 1'b1;
                        state_d = DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!cnt_match) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end else if (cnt_done) begin
                    state_d = HELD;
                    strobe  = 1'b1;
                end
            end
            HELD: begin
                if (cnt_done) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
        cnt_clr = (state_d != state_q);
    end

    // ---- stage p1: FSM, scan rotator and output registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            div_q     <= '0;
            col_idx_q <= 2'd0;
            cols_q    <= 4'b1110;
            pat_q     <= 4'hF;
            number_q  <= 4'h0;
            clean_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            clean_q <= strobe;
            held_q  <= (state_d == HELD);
            if (strobe) begin
                number_q <= decode_key(col_idx_q, row_index(pat_q));
            end
            if (latch) begin
                pat_q <= rows_s;
            end
            if (advance) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                cols_q    <= {cols_q[2:0], cols_q[3]};
            end else if (latch) begin
                div_q <= '0;
            end else if (state_q == SCAN) begin
                div_q <= div_q + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clock = ~clock;

    // Key layout as the user sees it, indexed [row][col].
    logic [3:0] keymap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Physical keypad: a pressed switch at (r,c) pulls row r low while column c is driven low.
    logic pressed [4][4];

    always_comb begin
        kp.rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !kp.cols[c]) kp.rows[r] = 1'b0;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe monitor: records every accepted code and flags back-to-back strobes.
    int         strobes = 0;
    logic [3:0] obs_q [$];
    logic       prev_clean = 1'b0;

    always @(negedge clock) begin
        if (kp.cleanSignal) begin
            strobes++;
            obs_q.push_back(kp.number);
            check("strobe_back_to_back", {31'd0, prev_clean}, 32'd0);
        end
        prev_clean <= kp.cleanSignal;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic wait_held(input string name);
        int k;
        k = 0;
        while (!kp.keyHeld && k < 200) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, kp.keyHeld}, 32'd1);
    endtask

    task automatic wait_cols(input string name, input logic [3:0] want);
        int k;
        k = 0;
        while (kp.cols !== want && k < 200) begin
            tick(1);
            k++;
        end
        check(name, {28'd0, kp.cols}, {28'd0, want});
    endtask

    typedef struct {
        int         r;
        int         c;
        int         hold;
        bit         bounce;
        int         exp_strobes;
        logic [3:0] exp_num;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int s0;
        int base;
        int rot;
        int bad_rot;
        int expi;
        logic [3:0] prev_cols;
        logic [3:0] exp_q [$];

        #20000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int base;
        int rot;
        int bad_rot;
        int idx;
        int r;
        int c;
        logic [3:0] prev_cols;
        logic [3:0] exp_q [$];

        tbl[0] = '{r: 1, c: 1, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'h5};
        tbl[1] = '{r: 2, c: 2, hold: 50, bounce: 1'b1, exp_strobes: 1, exp_num: 4'h9};
        tbl[2] = '{r: 3, c: 0, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'hE};
        tbl[3] = '{r: 3, c: 2, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'hF};
        tbl[4] = '{r: 1, c: 3, hold: 3,  bounce: 1'b0, exp_strobes: 0, exp_num: 4'hF};
        tbl[5] = '{r: 0, c: 3, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'hA};
        tbl[6] = '{r: 3, c: 1, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'h0};
        tbl[7] = '{r: 3, c: 3, hold: 60, bounce: 1'b0, exp_strobes: 1, exp_num: 4'hD};

        release_all();
        reset = 1'b1;
        tick(3);
        check("reset_cols",   {28'd0, kp.cols}, 32'h0000_000E);
        check("reset_number", {28'd0, kp.number}, 32'd0);
        check("reset_clean",  {31'd0, kp.cleanSignal}, 32'd0);
        check("reset_held",   {31'd0, kp.keyHeld}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Table-driven presses
        for (int i = 0; i < 8; i++) begin
            s0 = strobes;
            if (tbl[i].bounce) begin
                for (int k = 0; k < 20; k++) begin
                    pressed[tbl[i].r][tbl[i].c] = ((k / 3) % 2 == 0);
                    tick(1);
                end
                check($sformatf("tbl%0d_bounce_no_strobe", i), strobes - s0, 32'd0);
            end
            pressed[tbl[i].r][tbl[i].c] = 1'b1;
            tick(tbl[i].hold);
            release_all();
            tick(30);
            check($sformatf("tbl%0d_strobes", i), strobes - s0, tbl[i].exp_strobes);
            check($sformatf("tbl%0d_number", i), {28'd0, kp.number}, {28'd0, tbl[i].exp_num});
            check($sformatf("tbl%0d_held_after", i), {31'd0, kp.keyHeld}, 32'd0);
        end

        // keyHeld drops exactly 2 (sync) + DEBOUNCE_CNT cycles after release
        s0 = strobes;
        pressed[1][1] = 1'b1;
        wait_held("held5_rise");
        tick(20);
        check("held5_during", {31'd0, kp.keyHeld}, 32'd1);
        release_all();
        tick(2 + DEBOUNCE_CNT - 1);
        check("held5_before_drop", {31'd0, kp.keyHeld}, 32'd1);
        tick(1);
        check("held5_drop", {31'd0, kp.keyHeld}, 32'd0);
        tick(20);
        check("held5_strobes", strobes - s0, 32'd1);
        check("held5_number", {28'd0, kp.number}, 32'h5);

        // Two rows in the same column: ghosting, scan keeps rotating
        s0 = strobes;
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        prev_cols = kp.cols;
        rot = 0;
        bad_rot = 0;
        for (int k = 0; k < 48; k++) begin
            tick(1);
            if (kp.cols != prev_cols) begin
                idx = 0;
                for (int j = 0; j < 4; j++) if (!prev_cols[j]) idx = j;
                if (kp.cols != ~(4'b0001 << ((idx + 1) % 4))) bad_rot++;
                rot++;
                prev_cols = kp.cols;
            end
        end
        release_all();
        check("ghost_rotation_order", bad_rot, 32'd0);
        check("ghost_rotating", {31'd0, rot >= 10}, 32'd1);
        check("ghost_no_strobe", strobes - s0, 32'd0);
        tick(10);

        // Second key while HELD is ignored
        s0 = strobes;
        pressed[0][0] = 1'b1;
        wait_held("two_key_held");
        tick(5);
        pressed[0][1] = 1'b1;
        tick(30);
        release_all();
        tick(30);
        check("two_key_strobes", strobes - s0, 32'd1);
        check("two_key_number", {28'd0, kp.number}, 32'h1);

        // Asynchronous reset five cycles into DEBOUNCE of key 'C' (r2,c3)
        s0 = strobes;
        wait_cols("c_wait_col2", 4'b1011);
        pressed[2][3] = 1'b1;
        wait_cols("c_wait_col3", 4'b0111);
        tick(8);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_cols",   {28'd0, kp.cols}, 32'h0000_000E);
        check("rst_mid_number", {28'd0, kp.number}, 32'd0);
        check("rst_mid_clean",  {31'd0, kp.cleanSignal}, 32'd0);
        check("rst_mid_held",   {31'd0, kp.keyHeld}, 32'd0);
        release_all();
        tick(3);
        reset = 1'b0;
        tick(40);
        check("rst_mid_no_strobe", strobes - s0, 32'd0);
        check("rst_mid_number_after", {28'd0, kp.number}, 32'd0);

        // Randomized presses against the key-layout model
        base = obs_q.size();
        for (int n = 0; n < 12; n++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            exp_q.push_back(keymap[r][c]);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 12; k++) begin
                    pressed[r][c] = ((k / 3) % 2 == 0);
                    tick(1);
                end
            end
            pressed[r][c] = 1'b1;
            tick(int'($urandom_range(40, 60)));
            release_all();
            tick(int'($urandom_range(20, 30)));
        end
        check("rand_strobe_count", obs_q.size() - base, exp_q.size());
        for (int n = 0; n < exp_q.size(); n++) begin
            if (base + n < obs_q.size())
                check($sformatf("rand_code%0d", n), {28'd0, obs_q[base + n]}, {28'd0, exp_q[n]});
        end
        check("rand_final_number", {28'd0, kp.number}, {28'd0, exp_q[exp_q.size() - 1]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
